// File: rtl/bcd_encoder.sv
// Registered 10-to-4 decimal-to-BCD priority encoder.
// Flags any active line (valid) and multi-hot inputs (multi).
module bcd_encoder #(
  parameter bit HIGH_PRIORITY = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] in,
  output logic [3:0] out,
  output logic       valid,
  output logic       multi
);

  logic [3:0] code;
  logic       any;
  logic       many;

  // Pick the winning line; the later loop hit overrides earlier ones.
  always_comb begin
    code = 4'd0;
    if (HIGH_PRIORITY) begin
      for (int i = 0; i < 10; i++) begin
        if (in[i]) code = 4'(i);
      end
    end else begin
      for (int i = 9; i >= 0; i--) begin
        if (in[i]) code = 4'(i);
      end
    end
  end

  // Clearing the lowest set bit leaves something only if 2+ were set.
  always_comb begin
    any  = |in;
    many = |(in & (in - 10'd1));
  end

  // Output register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out   <= 4'd0;
      valid <= 1'b0;
      multi <= 1'b0;
    end else begin
      out   <= code;
      valid <= any;
      multi <= many;
    end
  end

endmodule

// File: tb/tb_bcd_encoder.sv
// Scoreboard bench for bcd_encoder.
// Runs both priority settings side by side on the same input.
module tb_bcd_encoder;

  logic       clk;
  logic       rst;
  logic [9:0] din;
  logic [3:0] out_h;
  logic       valid_h;
  logic       multi_h;
  logic [3:0] out_l;
  logic       valid_l;
  logic       multi_l;

  typedef struct packed {
    logic [3:0] oh;
    logic       vh;
    logic       mh;
    logic [3:0] ol;
    logic       vl;
    logic       ml;
  } obs_t;

  obs_t q[$];
  int total;
  int bad;

  bcd_encoder #(.HIGH_PRIORITY(1'b1)) u_hi (
    .clk(clk), .rst(rst), .in(din),
    .out(out_h), .valid(valid_h), .multi(multi_h)
  );

  bcd_encoder #(.HIGH_PRIORITY(1'b0)) u_lo (
    .clk(clk), .rst(rst), .in(din),
    .out(out_l), .valid(valid_l), .multi(multi_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t model(input logic r, input logic [9:0] x);
    obs_t e;
    int n;
    e = '0;
    if (r) return e;
    n = $countones(x);
    for (int i = 9; i >= 0; i--) begin
      if (x[i]) begin
        e.oh = 4'(i);
        break;
      end
    end
    for (int i = 0; i < 10; i++) begin
      if (x[i]) begin
        e.ol = 4'(i);
        break;
      end
    end
    e.vh = (n > 0);
    e.vl = (n > 0);
    e.mh = (n > 1);
    e.ml = (n > 1);
    return e;
  endfunction

  function automatic obs_t seen();
    return {out_h, valid_h, multi_h, out_l, valid_l, multi_l};
  endfunction

  task automatic apply(input logic r, input logic [9:0] x);
    @(negedge clk);
    rst = r;
    din = x;
    q.push_back(model(r, x));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [10:0] seq [3];
    obs_t e;
    obs_t g;
    seq[0] = {1'b1, 10'h3ff};
    seq[1] = {1'b1, 10'h3ff};
    seq[2] = {1'b0, 10'h3ff};
    for (int i = 0; i < 3; i++) begin
      apply(seq[i][10], seq[i][9:0]);
      e = q.pop_front();
      g = seen();
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL reset[%0d] got=%h want=%h", i, g, e);
      end
    end
  endtask

  task automatic test_onehot();
    obs_t e;
    obs_t g;
    for (int k = 0; k < 10; k++) begin
      apply(1'b0, 10'(1) << k);
      e = q.pop_front();
      g = seen();
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL onehot[%0d] got=%h want=%h", k, g, e);
      end
    end
  endtask

  task automatic test_zero();
    obs_t e;
    obs_t g;
    apply(1'b0, 10'd0);
    e = q.pop_front();
    g = seen();
    total++;
    if (g !== e || valid_h !== 1'b0) begin
      bad++;
      $display("FAIL zero got=%h want=%h", g, e);
    end
  endtask

  task automatic test_multihot();
    logic [9:0] v [3];
    obs_t e;
    obs_t g;
    v[0] = 10'b0000000011;
    v[1] = 10'b0010100000;
    v[2] = 10'b1111111111;
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, v[i]);
      e = q.pop_front();
      g = seen();
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL multihot[%0d] got=%h want=%h", i, g, e);
      end
    end
  endtask

  task automatic test_midstream_reset();
    obs_t e;
    obs_t g;
    logic [9:0] x;
    for (int i = 0; i < 24; i++) begin
      x = 10'($urandom_range(1, 1023));
      apply(i == 10, x);
      e = q.pop_front();
      g = seen();
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL midstream[%0d] in=%b got=%h want=%h", i, x, g, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t e;
    obs_t g;
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 10'b0100010100);
      e = q.pop_front();
      g = seen();
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL hold[%0d] got=%h want=%h", i, g, e);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    din   = 10'd0;
    test_reset();
    test_onehot();
    test_zero();
    test_multihot();
    test_midstream_reset();
    test_back_to_back();
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_left got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_encoder.md
Name: bcd_encoder

Overview:
Registered 10-to-4 decimal-to-BCD priority encoder. Converts a 10-line decimal input, where line k represents digit k, into a 4-bit BCD digit with a valid flag. It also flags inputs that have more than one line active. Used wherever discrete digit lines (keypad rows, selector switches) must be reduced to a BCD code for downstream BCD/7-segment logic.

Parameters:
HIGH_PRIORITY, 1, 1 = the highest-index active line wins; 0 = the lowest-index active line wins.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in  input  10  decimal lines; bit k asserted = digit k requested.
out  output  4  registered BCD code of the winning line (0-9).
valid  output  1  registered; 1 when at least one input line was active.
multi  output  1  registered; 1 when two or more input lines were active.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- All outputs are registered. Latency is exactly 1 cycle: the outputs after rising edge N reflect the value of in sampled at edge N.
- Reset: when rst=1 at a rising edge, out=4'd0, valid=0 and multi=0. Reset overrides the input sampled on that edge. The first post-reset edge with rst=0 loads the encoding normally.
- Encoding with HIGH_PRIORITY=1: out = index of the highest set bit of in.
- Encoding with HIGH_PRIORITY=0: out = index of the lowest set bit of in.
- out is always in the range 0-9. Codes 10-15 are never produced.
- in all zero: out=4'd0, valid=0, multi=0. out=0 is distinguished from "digit 0" only by valid.
- in[0] alone: out=4'd0, valid=1, multi=0.
- valid = OR of all 10 input bits.
- multi = 1 iff the population count of in is 2 or more. multi=1 always implies valid=1.
- Multi-hot inputs still produce a valid code, selected by the priority rule; multi is advisory only.
- No other state exists: the outputs are a pure registered function of the previous-cycle input. Holding in constant holds the outputs constant.
- in is treated as synchronous to clk; no synchronizer is included.

Test Plan:
- Reset: drive in=10'b1111111111 with rst=1 for 2 cycles -> out=0000, valid=0, multi=0. Release rst -> next edge gives out=1001, valid=1, multi=1.
- One-hot sweep (default parameter): apply in=1<<k for k=0..9, one per cycle -> out=k one cycle later, valid=1, multi=0 for every k.
- Zero input: in=10'b0000000000 -> out=0000, valid=0, multi=0. This must not be confused with the k=0 case, which gives valid=1.
- Multi-hot priority (HIGH_PRIORITY=1):
  - in=10'b0000000011 -> out=0001, multi=1.
  - in=10'b0010100000 -> out=0111, multi=1.
  - in=10'b1111111111 -> out=1001, valid=1, multi=1.
- Low priority (HIGH_PRIORITY=0), same three vectors -> out=0000, 0101, 0000 respectively; valid=1 and multi=1 for all three.
- Latency and reset mid-stream: change in every cycle and assert rst for one cycle in the middle. Outputs lag in by exactly 1 cycle; the cycle after the rst edge shows zeros; encoding resumes on the following edge.
